// File: rtl/edge_stream_select_if.sv
// Stream bundle for edge_stream_select: raw pixel tap, feature beats and the framer-facing output.
// master = upstream/framer side, slave = the selector itself.
interface edge_stream_select_if #(
   parameter int Channels  = 2,
   parameter int ConvWidth = 4,
   parameter int MagWidth  = 5,
   parameter int PixWidth  = 1
);
   logic [PixWidth-1:0]           raw_data_i;
   logic                          raw_valid_i;
   logic                          raw_ready_o;
   logic [Channels*ConvWidth-1:0] feat_data_i;
   logic [MagWidth-1:0]           mag_i;
   logic                          feat_valid_i;
   logic                          feat_ready_o;
   logic [PixWidth-1:0]           data_o;
   logic                          valid_o;
   logic                          ready_i;

   modport master (
      output raw_data_i, raw_valid_i, feat_data_i, mag_i, feat_valid_i, ready_i,
      input  raw_ready_o, feat_ready_o, data_o, valid_o
   );

   modport slave (
      input  raw_data_i, raw_valid_i, feat_data_i, mag_i, feat_valid_i, ready_i,
      output raw_ready_o, feat_ready_o, data_o, valid_o
   );
endinterface

// File: rtl/edge_stream_select.sv
// Frame-locked selector: raw pixels, one thresholded conv channel, or thresholded magnitude,
// behind a one-entry elastic output register. Define ABS_EDGE_EN to compare |ch| in channel modes.
module edge_stream_select #(
   parameter int Channels     = 2,
   parameter int ConvWidth    = 4,
   parameter int MagWidth     = 5,
   parameter int PixWidth     = 1,
   parameter int RawFrameLen  = 76800,
   parameter int FeatFrameLen = 75684,
   parameter int ModeWidth    = $clog2(Channels + 2)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [ModeWidth-1:0]          mode_i,
   input  logic [Channels*ConvWidth-1:0] thresh_i,
   input  logic [MagWidth-1:0]           mag_thresh_i,
   edge_stream_select_if.slave           strm,
   output logic [ModeWidth-1:0]          mode_o,
   output logic                          frame_done_o
);

   localparam int MaxLen   = (RawFrameLen > FeatFrameLen) ? RawFrameLen : FeatFrameLen;
   localparam int CntWidth = (MaxLen > 1) ? $clog2(MaxLen) : 1;

   localparam logic [ModeWidth-1:0] RawMode = '0;
   localparam logic [ModeWidth-1:0] MagMode = ModeWidth'(Channels + 1);
   localparam logic [CntWidth-1:0]  RawLast  = CntWidth'(RawFrameLen - 1);
   localparam logic [CntWidth-1:0]  FeatLast = CntWidth'(FeatFrameLen - 1);

   // Out-of-range mode requests fall back to magnitude mode.
   function automatic logic [ModeWidth-1:0] clamp_mode(input logic [ModeWidth-1:0] m);
      if (int'(m) > Channels + 1) return MagMode;
      return m;
   endfunction

   function automatic logic chan_edge(input logic signed [ConvWidth-1:0] ch,
                                      input logic signed [ConvWidth-1:0] th);
`ifdef ABS_EDGE_EN
      logic signed [ConvWidth:0] ch_ext;
      logic        [ConvWidth:0] ch_abs;
      ch_ext = {ch[ConvWidth-1], ch};
      ch_abs = ch_ext[ConvWidth] ? unsigned'(-ch_ext) : unsigned'(ch_ext);
      return ch_abs >= {1'b0, unsigned'(th)};
`else
      return ch >= th;
`endif
   endfunction

   logic [ModeWidth-1:0] mode_meta;
   logic [ModeWidth-1:0] mode_sync;
   logic [ModeWidth-1:0] mode_q;
   logic [CntWidth-1:0]  beat_cnt;

   logic                        sel_raw;
   logic                        slot_free;
   logic                        accept_p0;
   logic                        cnt_wrap_p0;
   logic signed [ConvWidth-1:0] ch_sel_p0;
   logic signed [ConvWidth-1:0] th_sel_p0;
   logic                        edge_p0;
   logic [PixWidth-1:0]         pix_p0;

   assign sel_raw   = (mode_q == RawMode);
   assign slot_free = ~strm.valid_o | strm.ready_i;

   // The unselected source is always ready so upstream never stalls; its beats are dropped.
   assign strm.raw_ready_o  = sel_raw ? slot_free : 1'b1;
   assign strm.feat_ready_o = sel_raw ? 1'b1 : slot_free;

   assign accept_p0   = slot_free & (sel_raw ? strm.raw_valid_i : strm.feat_valid_i);
   assign cnt_wrap_p0 = (beat_cnt == (sel_raw ? RawLast : FeatLast));

   always_comb begin
      ch_sel_p0 = '0;
      th_sel_p0 = '0;
      for (int c = 0; c < Channels; c++) begin
         if (int'(mode_q) == c + 1) begin
            ch_sel_p0 = strm.feat_data_i[c*ConvWidth +: ConvWidth];
            th_sel_p0 = thresh_i[c*ConvWidth +: ConvWidth];
         end
      end
   end

   always_comb begin
      edge_p0 = (mode_q == MagMode) ? (strm.mag_i >= mag_thresh_i)
                                    : chan_edge(ch_sel_p0, th_sel_p0);
      pix_p0  = '0;
      if (sel_raw) pix_p0    = strm.raw_data_i;
      else         pix_p0[0] = edge_p0;
   end

   // mode_i comes from the button domain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_meta <= '0;
         mode_sync <= '0;
      end else begin
         mode_meta <= mode_i;
         mode_sync <= mode_meta;
      end
   end

   // A beat accepted while the counter is 0 still uses the old mode and engages the lock.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q       <= MagMode;
         beat_cnt     <= '0;
         frame_done_o <= 1'b0;
      end else begin
         frame_done_o <= accept_p0 & cnt_wrap_p0;
         if (accept_p0) begin
            beat_cnt <= cnt_wrap_p0 ? '0 : beat_cnt + CntWidth'(1);
         end else if (beat_cnt == '0) begin
            mode_q <= clamp_mode(mode_sync);
         end
      end
   end

   // ---- stage p0 -> output register ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         strm.valid_o <= 1'b0;
         strm.data_o  <= '0;
      end else if (accept_p0) begin
         strm.valid_o <= 1'b1;
         strm.data_o  <= pix_p0;
      end else if (strm.ready_i) begin
         strm.valid_o <= 1'b0;
      end
   end

   assign mode_o = mode_q;

endmodule

// File: tb/tb_edge_stream_select.sv
// Scoreboard bench for edge_stream_select with 16-beat frames; the driver queues expected
// pixels on accept and a negedge monitor pops them on every output transfer.
module tb_edge_stream_select;
   localparam int Channels  = 2;
   localparam int ConvWidth = 4;
   localparam int MagWidth  = 5;
   localparam int PixWidth  = 1;
   localparam int FrameLen  = 16;
   localparam int ModeWidth = $clog2(Channels + 2);
`ifdef ABS_EDGE_EN
   localparam logic Abs = 1'b1;
`else
   localparam logic Abs = 1'b0;
`endif

   logic                          clk_i = 1'b0;
   logic                          rst_ni = 1'b1;
   logic [ModeWidth-1:0]          mode_i;
   logic [Channels*ConvWidth-1:0] thresh_i;
   logic [MagWidth-1:0]           mag_thresh_i;
   logic [ModeWidth-1:0]          mode_o;
   logic                          frame_done_o;

   edge_stream_select_if #(.Channels(Channels), .ConvWidth(ConvWidth),
                           .MagWidth(MagWidth), .PixWidth(PixWidth)) strm ();

   edge_stream_select #(
      .Channels(Channels), .ConvWidth(ConvWidth), .MagWidth(MagWidth), .PixWidth(PixWidth),
      .RawFrameLen(FrameLen), .FeatFrameLen(FrameLen)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .thresh_i(thresh_i),
      .mag_thresh_i(mag_thresh_i), .strm(strm), .mode_o(mode_o), .frame_done_o(frame_done_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [PixWidth-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && strm.valid_o && strm.ready_i) begin
         if (exp_q.size() == 0) check("unexpected_out", 32'(strm.data_o), 32'hdead);
         else check("out_data", 32'(strm.data_o), 32'(exp_q.pop_front()));
      end
      if (rst_ni && frame_done_o) done_cnt++;
   end

   task automatic idle(input int n);
      strm.raw_valid_i  = 1'b0;
      strm.feat_valid_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic send_feat(input logic signed [ConvWidth-1:0] c0, input logic signed [ConvWidth-1:0] c1,
                            input logic [MagWidth-1:0] m, input logic e);
      bit took = 0;
      strm.feat_data_i  = {c1, c0};
      strm.mag_i        = m;
      strm.feat_valid_i = 1'b1;
      strm.raw_valid_i  = 1'b1;
      strm.raw_data_i   = PixWidth'(~e);
      for (int i = 0; i < 20 && !took; i++) begin
         @(negedge clk_i);
         check("raw_ready_unsel", 32'(strm.raw_ready_o), 1);
         if (strm.feat_ready_o) begin
            exp_q.push_back(PixWidth'(e));
            took = 1;
         end
         @(posedge clk_i);
         #1;
      end
      if (!took) check("feat_accept_timeout", 0, 1);
   endtask

   task automatic send_raw(input logic [PixWidth-1:0] p);
      bit took = 0;
      strm.raw_data_i   = p;
      strm.raw_valid_i  = 1'b1;
      strm.feat_valid_i = 1'b1;
      strm.feat_data_i  = 8'h7f;
      strm.mag_i        = '1;
      for (int i = 0; i < 20 && !took; i++) begin
         @(negedge clk_i);
         check("feat_ready_unsel", 32'(strm.feat_ready_o), 1);
         if (strm.raw_ready_o) begin
            exp_q.push_back(p);
            took = 1;
         end
         @(posedge clk_i);
         #1;
      end
      if (!took) check("raw_accept_timeout", 0, 1);
   endtask

   task automatic start_section(input logic [ModeWidth-1:0] m);
      rst_ni = 1'b0;
      strm.raw_valid_i  = 1'b0;
      strm.feat_valid_i = 1'b0;
      mode_i = m;
      #3;
      exp_q.delete();
      check("rst_valid", 32'(strm.valid_o), 0);
      check("rst_mode", 32'(mode_o), 3);
      check("rst_done", 32'(frame_done_o), 0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      strm.ready_i = 1'b1;
      idle(5);
      check("mode_after_idle", 32'(mode_o), 32'(m));
   endtask

   task automatic drain(input string name);
      idle(4);
      check(name, 32'(exp_q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mode_i = 3;
      thresh_i = 8'h32;            // ch1 threshold 3, ch0 threshold 2
      mag_thresh_i = 5'd4;
      strm.ready_i = 1'b1;
      strm.raw_valid_i = 1'b0;
      strm.feat_valid_i = 1'b0;
      strm.raw_data_i = '0;
      strm.feat_data_i = '0;
      strm.mag_i = '0;
      #2;

      // Mode 1: ch0 vs 2; ch1/mag chosen to disagree with the expected edge.
      start_section(2'd1);
      send_feat(4'sd2, 4'sd0, 5'd31, 1'b1);
      send_feat(4'sd1, 4'sd7, 5'd0, 1'b0);
      send_feat(-4'sd3, 4'sd7, 5'd0, Abs);
      send_feat(-4'sd8, 4'sd0, 5'd31, Abs);
      send_feat(4'sd7, -4'sd8, 5'd0, 1'b1);
      drain("drain_mode1");

      // Mode 2: ch1 vs 3.
      start_section(2'd2);
      send_feat(4'sd7, 4'sd3, 5'd0, 1'b1);
      send_feat(4'sd7, 4'sd2, 5'd31, 1'b0);
      send_feat(4'sd0, -4'sd8, 5'd31, Abs);
      send_feat(-4'sd8, 4'sd7, 5'd0, 1'b1);
      drain("drain_mode2");

      // Mode 3: mag vs 4, then backpressure.
      start_section(2'd3);
      send_feat(4'sd7, 4'sd7, 5'd3, 1'b0);
      send_feat(4'sd7, 4'sd7, 5'd4, 1'b1);
      send_feat(-4'sd8, -4'sd8, 5'd5, 1'b1);
      send_feat(-4'sd8, -4'sd8, 5'd31, 1'b1);
      send_feat(4'sd7, 4'sd7, 5'd0, 1'b0);
      send_feat(4'sd0, 4'sd0, 5'd5, 1'b1);
      strm.ready_i = 1'b0;
      fork
         send_feat(4'sd0, 4'sd0, 5'd3, 1'b0);
         begin
            repeat (5) begin
               @(negedge clk_i);
               check("bp_data_hold", 32'(strm.data_o), 1);
               check("bp_valid_hold", 32'(strm.valid_o), 1);
               check("bp_feat_ready", 32'(strm.feat_ready_o), 0);
            end
            @(posedge clk_i);
            #1;
            strm.ready_i = 1'b1;
         end
      join
      drain("drain_bp");

      // Mode 0: raw passthrough, then leave a beat stuck in the output register.
      start_section(2'd0);
      send_raw(1'b1);
      send_raw(1'b0);
      send_raw(1'b1);
      send_raw(1'b0);
      send_raw(1'b1);
      send_raw(1'b1);
      drain("drain_raw");
      send_raw(1'b1);
      strm.ready_i = 1'b0;
      idle(2);
      check("pre_rst_valid", 32'(strm.valid_o), 1);
      check("pre_rst_data", 32'(strm.data_o), 1);

      // Mid-stream reset, then a full frame with a mode request arriving at beat 5.
      start_section(2'd3);
      done_cnt = 0;
      for (int i = 0; i < FrameLen; i++) begin
         if (i == 5) mode_i = 2'd1;
         check("lock_mode_hold", 32'(mode_o), 3);
         if (i % 2 == 1) send_feat(-4'sd8, 4'sd0, 5'd5, 1'b1);
         else            send_feat(4'sd7, 4'sd0, 5'd3, 1'b0);
      end
      strm.feat_valid_i = 1'b0;
      strm.raw_valid_i  = 1'b0;
      @(negedge clk_i);
      check("frame_done_pulse", 32'(frame_done_o), 1);
      check("mode_at_wrap", 32'(mode_o), 3);
      @(posedge clk_i);
      #1;
      check("mode_new_frame", 32'(mode_o), 1);
      send_feat(4'sd2, 4'sd0, 5'd0, 1'b1);
      drain("drain_lock");
      check("frame_done_count", 32'(done_cnt), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
